// File: rtl/cdec8_mem_arb.sv
// Single-port RAM arbiter: CDEC8 CPU port (combinational, priority) vs. debug peek/poke port.
// Define CDEC8_ARB_FAIR_EN for the bounded-wait forced debug grant; otherwise strict CPU priority.
module cdec8_mem_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] cpu_mmrw_i,
  input  logic [7:0] cpu_adrs_i,
  input  logic [7:0] cpu_wdata_i,
  output logic [7:0] cpu_rdata_o,
  output logic       cpu_stall_o,
  input  logic       dbg_req_i,
  input  logic       dbg_we_i,
  input  logic [7:0] dbg_adrs_i,
  input  logic [7:0] dbg_wdata_i,
  output logic       dbg_ack_o,
  output logic [7:0] dbg_rdata_o,
  output logic [7:0] ram_adrs_o,
  output logic [7:0] ram_wdata_o,
  output logic       ram_we_o,
  input  logic [7:0] ram_rdata_i
);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e     state_q, state_d;
  logic [7:0] dbg_rdata_q, dbg_rdata_d;
  logic       cpu_act;
  logic       pend;
  logic       force_gnt;
  logic       gnt_dbg;

  assign cpu_act = (cpu_mmrw_i == 2'b10) || (cpu_mmrw_i == 2'b01);
  assign pend    = dbg_req_i && (state_q == StIdle);
  assign gnt_dbg = pend && (!cpu_act || force_gnt);

`ifdef CDEC8_ARB_FAIR_EN
  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign force_gnt = (wait_cnt_q == MaxWaitC);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!pend || gnt_dbg) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MaxWaitC) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A forced grant is the only way debug can own the RAM while the CPU is active.
  assign cpu_stall_o = gnt_dbg && cpu_act;
`else
  logic [3:0] unused_max_wait;

  assign unused_max_wait = 4'(MAX_WAIT);
  assign force_gnt       = 1'b0;
  assign cpu_stall_o     = 1'b0;
`endif

  always_comb begin
    ram_adrs_o  = cpu_adrs_i;
    ram_wdata_o = cpu_wdata_i;
    ram_we_o    = (cpu_mmrw_i == 2'b01);
    if (gnt_dbg) begin
      ram_adrs_o  = dbg_adrs_i;
      ram_wdata_o = dbg_wdata_i;
      ram_we_o    = dbg_we_i;
    end
    // Reset aborts any write in flight, including one in a debug grant cycle.
    if (reset_i) begin
      ram_we_o = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_dbg) begin
          state_d = StAck;
          if (!dbg_we_i) begin
            dbg_rdata_d = ram_rdata_i;
          end
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      dbg_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_ack_o   = (state_q == StAck);
  assign dbg_rdata_o = dbg_rdata_q;
  assign cpu_rdata_o = ram_rdata_i;

endmodule
